// File: rtl/module_keypad_scanner.sv
// module_keypad_scanner
//   Scans a 4x4 hex keypad and turns each accepted press into a hex nibble.
//   The columns are driven active-low, one at a time. The rows are pulled up
//   and read as active-low. Each press is debounced, decoded and shifted into
//   a 32-bit digit register, which can drive the display input of the 7-seg
//   control block.
//
// Ports
//   clk_10Mhz_i    in   1   system clock (single domain)
//   reset_i        in   1   asynchronous reset, active-low
//   row_i          in   4   keypad rows, active-low, asynchronous
//   col_o          out  4   keypad column drive, one-cold
//   key_o          out  4   last accepted key code (held until next key)
//   key_valid_o    out  1   one-cycle strobe for a new key
//   key_pressed_o  out  1   high while an accepted key is still held
//   digits_o       out  32  last 8 key codes, newest in [3:0]
//   state_o        out  2   current scanner state (debug visibility)
//
// Output handshake: key_valid_o is a pure strobe with no ready/back-pressure.
// It is high for exactly one clock per accepted press. key_o and digits_o
// already carry the new key in that same cycle.
module module_keypad_scanner #(
    parameter int COUNT_SCAN     = 10_000,
    parameter int BITS_SCAN      = 14,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BITS_DEB       = 5
) (
    input  logic        clk_10Mhz_i,
    input  logic        reset_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic        key_pressed_o,
    output logic [31:0] digits_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    localparam logic [BITS_SCAN-1:0] TICK_LAST = BITS_SCAN'(COUNT_SCAN - 1);
    localparam logic [BITS_DEB-1:0]  DEB_LAST  = BITS_DEB'(DEBOUNCE_TICKS - 1);

    state_t              state;
    logic [3:0]          row_m;
    logic [3:0]          row_s;
    logic [BITS_SCAN-1:0] dwell_cnt;
    logic                tick;
    logic [1:0]          col_idx;
    logic [1:0]          next_col;
    logic [1:0]          cand_row;
    logic [1:0]          cand_col;
    logic [BITS_DEB-1:0] deb_cnt;
    logic [BITS_DEB-1:0] rel_cnt;
    logic                row_idle;
    logic [1:0]          win_row;
    logic [3:0]          cand_code;

    // Keypad legend, row-major. '*' reads as E and '#' reads as F.
    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Two-flop synchroniser. It idles high, which means no key is down.
    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row_i;
            row_s <= row_m;
        end
    end

    // Free-running dwell counter. It runs in every state, so debounce and
    // release timing use the same tick as the column scan.
    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt == TICK_LAST) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    assign tick     = (dwell_cnt == TICK_LAST);
    assign row_idle = (row_s == 4'hF);
    assign next_col = col_idx + 2'd1;
    assign cand_code = decode(cand_row, cand_col);
    assign state_o  = state;

    // With several rows low, the lowest row index wins.
    always_comb begin
        win_row = 2'd3;
        if (!row_s[0])      win_row = 2'd0;
        else if (!row_s[1]) win_row = 2'd1;
        else if (!row_s[2]) win_row = 2'd2;
    end

    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            state         <= ST_SCAN;
            col_idx       <= 2'd0;
            col_o         <= 4'b1110;
            cand_row      <= 2'd0;
            cand_col      <= 2'd0;
            deb_cnt       <= '0;
            rel_cnt       <= '0;
            key_o         <= 4'h0;
            key_valid_o   <= 1'b0;
            key_pressed_o <= 1'b0;
            digits_o      <= 32'h0;
        end else begin
            key_valid_o <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (tick) begin
                        if (row_idle) begin
                            col_idx <= next_col;
                            col_o   <= col_drive(next_col);
                        end else begin
                            // Freeze the column on the candidate. The first tick
                            // that sees it counts as the first match.
                            cand_row <= win_row;
                            cand_col <= col_idx;
                            deb_cnt  <= BITS_DEB'(1);
                            state    <= ST_DEBOUNCE;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (tick) begin
                        if (!row_idle && win_row == cand_row) begin
                            if (deb_cnt >= DEB_LAST) begin
                                state         <= ST_HOLD;
                                deb_cnt       <= '0;
                                rel_cnt       <= '0;
                                key_valid_o   <= 1'b1;
                                key_pressed_o <= 1'b1;
                                key_o         <= cand_code;
                                digits_o      <= {digits_o[27:0], cand_code};
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state   <= ST_SCAN;
                            deb_cnt <= '0;
                            col_idx <= next_col;
                            col_o   <= col_drive(next_col);
                        end
                    end
                end

                ST_HOLD: begin
                    // A release counts only after DEBOUNCE_TICKS consecutive idle
                    // ticks. Any low row restarts the count, so bounce cannot
                    // cause a second strobe.
                    if (tick) begin
                        if (row_idle) begin
                            if (rel_cnt >= DEB_LAST) begin
                                state         <= ST_SCAN;
                                rel_cnt       <= '0;
                                key_pressed_o <= 1'b0;
                                col_idx       <= next_col;
                                col_o         <= col_drive(next_col);
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule
